// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/divider/memory stalls, exception flushes.
// Optional performance counters are built in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int HILO_W  = 2,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              branchD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic              regwriteE,
   input  logic              memtoregE,
   input  logic              divE,
   input  logic [HILO_W-1:0] hilowriteE,
   input  logic [HILO_W-1:0] hilowriteM,
   input  logic [HILO_W-1:0] hilowriteW,
   input  logic [REG_AW-1:0] writeregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteM,
   input  logic              memtoregM,
   input  logic              regwriteW,
   input  logic              d_stall,
   input  logic              except_flush,
   output logic              forwardaD,
   output logic              forwardbD,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic [1:0]        forwardhiloE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              stallW,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW,
   output logic              div_start,
   output logic              div_done,
   output logic              div_busy,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  div_count
);

   localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            lwstall, brstall, div_stall, stall_e_raw;

   // M-stage result is younger than W, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (src != '0 && src == writeregM && regwriteM)
         return 2'b10;
      else if (src != '0 && src == writeregW && regwriteW)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign forwardaE = fwd_sel(rsE);
   assign forwardbE = fwd_sel(rtE);
   assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
   assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

   always_comb begin
      forwardhiloE = 2'b00;
      if (hilowriteE == '0 && hilowriteM != '0)
         forwardhiloE = 2'b01;
      else if (hilowriteW != '0)
         forwardhiloE = 2'b10;
   end

   assign lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
   assign brstall = branchD &&
                    ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

   assign div_stall   = ((state_q == IDLE) && divE) || ((state_q == BUSY) && (cnt_q != '0));
   assign stall_e_raw = d_stall || div_stall;

   // An exception overrides every stall so the flush actually takes effect.
   assign stallF = !except_flush && (stall_e_raw || lwstall || brstall);
   assign stallD = stallF;
   assign stallE = !except_flush && stall_e_raw;
   assign stallM = !except_flush && d_stall;
   assign stallW = stallM;

   assign flushD = except_flush;
   assign flushE = except_flush || ((lwstall || brstall) && !stall_e_raw);
   assign flushM = except_flush;
   assign flushW = except_flush;

   assign div_busy  = (state_q == BUSY);
   assign div_start = (state_q == IDLE) && divE && !except_flush && !d_stall;
   assign div_done  = (state_q == BUSY) && (cnt_q == '0) && !except_flush && !d_stall;

   always_ff @(posedge clk) begin
      if (rst || except_flush) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (!d_stall) begin
         case (state_q)
            IDLE: begin
               if (divE) begin
                  state_q <= BUSY;
                  cnt_q   <= CW'(DIV_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt_q != '0)
                  cnt_q <= cnt_q - CW'(1);
               else
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q, div_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         div_count_q    <= '0;
      end else begin
         if (stallF && (stall_cycles_q != '1))
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         if (div_done && (div_count_q != '1))
            div_count_q <= div_count_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign div_count    = div_count_q;
`else
   assign stall_cycles = '0;
   assign div_count    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (DIV_LAT=4): table of combinational vectors plus divider sequences,
// with expectations pushed to a scoreboard queue and compared after the outputs settle.
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 32;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic          rst;
      logic [AW-1:0] rsD, rtD;
      logic          branchD;
      logic [AW-1:0] rsE, rtE, writeregE;
      logic          regwriteE, memtoregE, divE;
      logic [1:0]    hiloE, hiloM, hiloW;
      logic [AW-1:0] writeregM, writeregW;
      logic          regwriteM, memtoregM, regwriteW, d_stall, except_flush;
   } vec_t;

   // fwd = {aD,bD,aE,bE,hiloE}; st = {F,D,E,M,W}; fl = {D,E,M,W}; dv = {start,done,busy}
   typedef struct {
      vec_t       in;
      logic [7:0] fwd;
      logic [4:0] st;
      logic [3:0] fl;
      logic [2:0] dv;
   } row_t;

   typedef struct {
      logic [7:0]    fwd;
      logic [4:0]    st;
      logic [3:0]    fl;
      logic [2:0]    dv;
      logic [CW-1:0] sc, dc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW;
   logic [1:0]    hilowriteE, hilowriteM, hilowriteW;
   logic          d_stall, except_flush;
   logic          forwardaD, forwardbD;
   logic [1:0]    forwardaE, forwardbE, forwardhiloE;
   logic          stallF, stallD, stallE, stallM, stallW;
   logic          flushD, flushE, flushM, flushW;
   logic          div_start, div_done, div_busy;
   logic [CW-1:0] stall_cycles, div_count;

   int            checks = 0;
   int            errors = 0;
   int            step_no = 0;
   logic [CW-1:0] exp_sc = '0;
   logic [CW-1:0] exp_dc = '0;
   exp_t          sb[$];
   row_t          tbl[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(AW), .HILO_W(2), .DIV_LAT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .branchD(branchD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE),
      .hilowriteE(hilowriteE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
      .writeregM(writeregM), .writeregW(writeregW),
      .regwriteM(regwriteM), .memtoregM(memtoregM), .regwriteW(regwriteW),
      .d_stall(d_stall), .except_flush(except_flush),
      .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardhiloE(forwardhiloE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_start(div_start), .div_done(div_done), .div_busy(div_busy),
      .stall_cycles(stall_cycles), .div_count(div_count)
   );

   task automatic drive(input vec_t v);
      rst = v.rst; rsD = v.rsD; rtD = v.rtD; branchD = v.branchD;
      rsE = v.rsE; rtE = v.rtE; writeregE = v.writeregE;
      regwriteE = v.regwriteE; memtoregE = v.memtoregE; divE = v.divE;
      hilowriteE = v.hiloE; hilowriteM = v.hiloM; hilowriteW = v.hiloW;
      writeregM = v.writeregM; writeregW = v.writeregW;
      regwriteM = v.regwriteM; memtoregM = v.memtoregM; regwriteW = v.regwriteW;
      d_stall = v.d_stall; except_flush = v.except_flush;
   endtask

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
      end
   endtask

   // One cycle: drive away from the edge, queue the expectation, compare after settling.
   task automatic step(input vec_t v, input logic [7:0] fwd, input logic [4:0] st,
                       input logic [3:0] fl, input logic [2:0] dv);
      exp_t e, got;
      @(negedge clk);
      drive(v);
      e.fwd = fwd; e.st = st; e.fl = fl; e.dv = dv;
      e.sc  = PERF ? exp_sc : '0;
      e.dc  = PERF ? exp_dc : '0;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL step %0d scoreboard: got empty expected entry", step_no);
      end else begin
         got = sb.pop_front();
         check("fwd",   32'({forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE}), 32'(got.fwd));
         check("stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'(got.st));
         check("flush", 32'({flushD, flushE, flushM, flushW}), 32'(got.fl));
         check("div",   32'({div_start, div_done, div_busy}), 32'(got.dv));
         check("stall_cycles", stall_cycles, got.sc);
         check("div_count",    div_count,    got.dc);
         $display("step %0d fwd=%b st=%b fl=%b dv=%b sc=%0d dc=%0d", step_no,
                  {forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE},
                  {stallF, stallD, stallE, stallM, stallW},
                  {flushD, flushE, flushM, flushW},
                  {div_start, div_done, div_busy}, stall_cycles, div_count);
         if (v.rst) begin
            exp_sc = '0; exp_dc = '0;
         end else begin
            if (got.st[4] && exp_sc != '1) exp_sc = exp_sc + 1;
            if (got.dv[1] && exp_dc != '1) exp_dc = exp_dc + 1;
         end
      end
      step_no++;
   endtask

   task automatic add(input vec_t v, input logic [7:0] fwd, input logic [4:0] st,
                      input logic [3:0] fl, input logic [2:0] dv);
      row_t r;
      r.in = v; r.fwd = fwd; r.st = st; r.fl = fl; r.dv = dv;
      tbl.push_back(r);
   endtask

   initial begin
      vec_t v;

      // Combinational vectors, FSM idle and divE low throughout.
      v = '0;                                                         add(v, 8'h00, 5'b00000, 4'b0000, 3'b000);
      v = '0; v.rsE = 3; v.writeregM = 3; v.regwriteM = 1;
              v.writeregW = 3; v.regwriteW = 1;                       add(v, 8'b00_10_00_00, 5'b0, 4'b0, 3'b0);
      v.rsE = 0;                                                      add(v, 8'b00_00_00_00, 5'b0, 4'b0, 3'b0);
      v = '0; v.rtE = 7; v.writeregW = 7; v.regwriteW = 1;            add(v, 8'b00_00_01_00, 5'b0, 4'b0, 3'b0);
      v = '0; v.rsE = 4; v.writeregM = 4; v.writeregW = 4;
              v.regwriteW = 1;                                        add(v, 8'b00_01_00_00, 5'b0, 4'b0, 3'b0);
      v = '0; v.rsD = 9; v.rtD = 9; v.writeregM = 9; v.regwriteM = 1; add(v, 8'b11_00_00_00, 5'b0, 4'b0, 3'b0);
      v = '0; v.hiloM = 2'b01;                                        add(v, 8'b00_00_00_01, 5'b0, 4'b0, 3'b0);
      v = '0; v.hiloE = 2'b01; v.hiloM = 2'b01; v.hiloW = 2'b10;      add(v, 8'b00_00_00_10, 5'b0, 4'b0, 3'b0);
      v = '0; v.hiloE = 2'b01; v.hiloM = 2'b01;                       add(v, 8'b00_00_00_00, 5'b0, 4'b0, 3'b0);
      v = '0; v.memtoregE = 1; v.rtE = 8; v.rsD = 8;                  add(v, 8'h00, 5'b11000, 4'b0100, 3'b0);
      v = '0; v.memtoregE = 1;                                        add(v, 8'h00, 5'b00000, 4'b0000, 3'b0);
      v = '0; v.memtoregE = 1; v.rtE = 6; v.rtD = 6; v.rsD = 1;       add(v, 8'h00, 5'b11000, 4'b0100, 3'b0);
      v = '0; v.branchD = 1; v.regwriteE = 1; v.writeregE = 5;
              v.rsD = 5;                                              add(v, 8'h00, 5'b11000, 4'b0100, 3'b0);
      v = '0; v.branchD = 1; v.memtoregM = 1; v.writeregM = 12;
              v.rtD = 12;                                             add(v, 8'h00, 5'b11000, 4'b0100, 3'b0);
      v = '0; v.branchD = 1; v.regwriteE = 1;                         add(v, 8'h00, 5'b00000, 4'b0000, 3'b0);
      v = '0; v.d_stall = 1;                                          add(v, 8'h00, 5'b11111, 4'b0000, 3'b0);
      v = '0; v.d_stall = 1; v.memtoregE = 1; v.rtE = 8; v.rsD = 8;   add(v, 8'h00, 5'b11111, 4'b0000, 3'b0);
      v.except_flush = 1;                                             add(v, 8'h00, 5'b00000, 4'b1111, 3'b0);

      v = '0; v.rst = 1;
      drive(v);
      repeat (2) @(posedge clk);
      step(v, 8'h00, 5'b0, 4'b0, 3'b000);

      foreach (tbl[i]) step(tbl[i].in, tbl[i].fwd, tbl[i].st, tbl[i].fl, tbl[i].dv);

      // Back-to-back divides: four stall cycles each, second starts right after the first's done.
      v = '0; v.divE = 1;
      for (int k = 0; k < 2; k++) begin
         step(v, 8'h00, 5'b11100, 4'b0, 3'b100);
         repeat (3) step(v, 8'h00, 5'b11100, 4'b0, 3'b001);
         step(v, 8'h00, 5'b00000, 4'b0, 3'b011);
      end
      v.divE = 0;
      step(v, 8'h00, 5'b0, 4'b0, 3'b000);

      // Memory stall mid-divide freezes the countdown for two cycles.
      v.divE = 1;
      step(v, 8'h00, 5'b11100, 4'b0, 3'b100);
      step(v, 8'h00, 5'b11100, 4'b0, 3'b001);
      v.d_stall = 1;
      repeat (2) step(v, 8'h00, 5'b11111, 4'b0, 3'b001);
      v.d_stall = 0;
      repeat (2) step(v, 8'h00, 5'b11100, 4'b0, 3'b001);
      step(v, 8'h00, 5'b00000, 4'b0, 3'b011);
      v.divE = 0;
      step(v, 8'h00, 5'b0, 4'b0, 3'b000);

      // Exception two cycles into a divide aborts it with no done.
      v.divE = 1;
      step(v, 8'h00, 5'b11100, 4'b0, 3'b100);
      step(v, 8'h00, 5'b11100, 4'b0, 3'b001);
      v.except_flush = 1;
      step(v, 8'h00, 5'b00000, 4'b1111, 3'b001);
      v = '0;
      repeat (2) step(v, 8'h00, 5'b0, 4'b0, 3'b000);

      // Branch hazard during a divider stall: held, not flushed; then reset aborts the divide.
      v = '0; v.divE = 1; v.branchD = 1; v.regwriteE = 1; v.writeregE = 5; v.rsD = 5;
      step(v, 8'h00, 5'b11100, 4'b0000, 3'b100);
      v = '0; v.rst = 1;
      step(v, 8'h00, 5'b11100, 4'b0000, 3'b001);
      v = '0;
      repeat (2) step(v, 8'h00, 5'b0, 4'b0, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core: data forwarding, load-use and branch-compare stalls, and a multi-cycle divider interlock. It also covers data-memory wait stalls and exception flushes. It sits beside the datapath, takes register indices and control bits from D/E/M/W, and drives per-stage stall/flush and forwarding selects. It supersedes the purely combinational hazard unit by adding the divider busy FSM, per-stage stall/flush, and optional performance counters.

## Interface
- REG_AW, 5, register index width
- HILO_W, 2, width of hilo write-enable bundle
- DIV_LAT, 32, divider latency in cycles (≥1)
- CNT_W, 32, perf counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rsD, rtD  in  REG_AW  D-stage source regs
- branchD  in  1  branch compare in D
- rsE, rtE, writeregE  in  REG_AW  E-stage regs
- regwriteE, memtoregE, divE  in  1  E-stage controls; divE = div/divu in E
- hilowriteE, hilowriteM, hilowriteW  in  HILO_W  hilo writes per stage
- writeregM, writeregW  in  REG_AW  destinations
- regwriteM, memtoregM, regwriteW  in  1  controls
- d_stall  in  1  data memory not ready
- except_flush  in  1  exception committed in M
- forwardaD, forwardbD  out  1  M→D forward
- forwardaE, forwardbE, forwardhiloE  out  2  E forward selects (00 reg, 01 W, 10 M; hilo 01 M, 10 W)
- stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
- flushD, flushE, flushM, flushW  out  1  clear stage register
- div_start, div_done, div_busy  out  1  divider handshake
- stall_cycles, div_count  out  CNT_W  perf counters

## Operation
- Forwarding: reg 0 never forwarded. M beats W. forwardaD/bD = src≠0 && src==writeregM && regwriteM. forwardhiloE = 01 if hilowriteE==0 && hilowriteM≠0, else 10 if hilowriteW≠0, else 00.
- lwstall = memtoregE && rtE≠0 && (rtE==rsD || rtE==rtD).
- brstall = branchD && ((regwriteE && writeregE≠0 && writeregE∈{rsD,rtD}) || (memtoregM && writeregM≠0 && writeregM∈{rsD,rtD})).
- Divider FSM, states IDLE/BUSY, counter cnt:
  - IDLE, divE && !except_flush && !d_stall: div_start=1, → BUSY, cnt=DIV_LAT-1.
  - BUSY, cnt≠0: cnt−1.
  - BUSY, cnt==0: div_done=1, → IDLE.
- div_busy = state==BUSY.
- div_stall = (IDLE && divE) || (BUSY && cnt≠0).
- Stall/flush equations:
  - stallF = stallD = d_stall || div_stall || lwstall || brstall.
  - stallE = d_stall || div_stall.
  - stallM = stallW = d_stall.
  - flushE = (lwstall || brstall) && !stallE.
- Exception has priority: except_flush forces flushD/E/M/W=1 and all stalls 0. FSM → IDLE, cnt=0, no div_done that cycle.
- d_stall freezes the FSM, including cnt.

## Timing
- All forwarding/stall/flush outputs are combinational from the current-cycle inputs and FSM state.
- Divider with no d_stall and no exception:
  - divE first seen at cycle t.
  - E is held for cycles t..t+DIV_LAT−1.
  - div_done is asserted at t+DIV_LAT and the instruction leaves E at the end of that cycle.
  - DIV_LAT stall cycles total.
- DIV_LAT=1: div_start at t, div_done at t+1.
- Back-to-back divides: the second starts the cycle after the first's div_done.
- Reset values: state IDLE, cnt 0, counters 0. All outputs follow the equations with those values; with all inputs 0 every output is 0.
- Reset mid-division aborts: the next cycle is IDLE with no div_done.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles +1 on every cycle with stallF=1; div_count +1 on every div_done. Both saturate at all-ones and clear on rst.
- HAZARD_PERF_EN undefined: no counter registers; stall_cycles and div_count tied to 0.

## Test plan
- Forward priority: rsE=3, writeregM=3/regwriteM=1, writeregW=3/regwriteW=1 → forwardaE=10. Same with rsE=0 → 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1, stallE=0. Same with rtE=0 → all 0.
- Divide, DIV_LAT=4: divE held high → div_start at t; stallE=1 for t..t+3; div_done=1 and stallE=0 at t+4; div_count=1 (PERF).
- d_stall=1 for 2 cycles mid-divide → cnt frozen, div_done delayed by 2 cycles; stallM=stallW=1 during the stall.
- except_flush at t+2 of a divide → flushD..W=1, stalls 0; FSM IDLE at t+3; no div_done.
- Branch stall: branchD=1, regwriteE=1, writeregE=rsD=5, while div_stall=1 → stallD=1, flushE=0.
